// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package bit_serial_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit counter width for a given operand width; wide enough to hold 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum_out,
   output logic carry_out
);

   assign sum_out   = a ^ b ^ c;
   assign carry_out = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder plus a registered carry, LSB first.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start_in; outputs hold the last completed result
//   ST_SHIFT | one operand bit pair is added per clock; busy_out is high
module bit_serial_adder
   import bit_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rstn_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry_q;
   logic             fa_sum;
   logic             fa_carry;
   logic             accept;
   logic             finish;

   full_adder u_fa (
      .a         (a_sr[0]),
      .b         (b_sr[0]),
      .c         (carry_q),
      .sum_out   (fa_sum),
      .carry_out (fa_carry)
   );

   // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign res_next = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rstn_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; accept/finish qualify the datapath updates.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, per-bit shift/add, and result/handshake registers.
   always_ff @(posedge clk_in) begin
      if (!rstn_in) begin
         cnt_q     <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         carry_q   <= 1'b0;
         busy_out  <= 1'b0;
         done_out  <= 1'b0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         if (accept) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            carry_q  <= c_in;
            cnt_q    <= '0;
            busy_out <= 1'b1;
         end else if (state_q == ST_SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= res_next;
            carry_q <= fa_carry;
            if (finish) begin
               cnt_q     <= '0;
               sum_out   <= res_next;
               carry_out <= fa_carry;
               done_out  <= 1'b1;
               busy_out  <= 1'b0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases at WIDTH=8 and a
// randomized regression over WIDTH 1, 8 and 16 against plain integer addition.
module tb_bit_serial_adder;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        c;

   logic        busy8, done8, co8;
   logic [7:0]  sum8;
   logic        busy1, done1, co1;
   logic [0:0]  sum1;
   logic        busy16, done16, co16;
   logic [15:0] sum16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) dut8 (
      .clk_in(clk), .rstn_in(rstn), .start_in(start),
      .a_in(a[7:0]), .b_in(b[7:0]), .c_in(c),
      .busy_out(busy8), .done_out(done8), .sum_out(sum8), .carry_out(co8)
   );

   bit_serial_adder #(.WIDTH(1)) dut1 (
      .clk_in(clk), .rstn_in(rstn), .start_in(start),
      .a_in(a[0:0]), .b_in(b[0:0]), .c_in(c),
      .busy_out(busy1), .done_out(done1), .sum_out(sum1), .carry_out(co1)
   );

   bit_serial_adder #(.WIDTH(16)) dut16 (
      .clk_in(clk), .rstn_in(rstn), .start_in(start),
      .a_in(a), .b_in(b), .c_in(c),
      .busy_out(busy16), .done_out(done16), .sum_out(sum16), .carry_out(co16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 operation: reports tick index of done (after accept = 0) and busy count.
   task automatic run8(input logic [7:0] ra, input logic [7:0] rb, input logic rc,
                       output int done_at, output int busy_n);
      a = 16'(ra); b = 16'(rb); c = rc; start = 1'b1;
      tick();
      start = 1'b0;
      done_at = -1;
      busy_n  = 0;
      for (int j = 0; j <= 20; j++) begin
         if (j > 0) tick();
         if (busy8) busy_n++;
         if (done8) begin
            done_at = j;
            break;
         end
      end
   endtask

   task automatic directed8(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                            input logic rc);
      int done_at, busy_n;
      logic [8:0] exp;
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, done_at, busy_n);
      chk({tag, "_lat"}, 32'(done_at), 32'd8);
      chk({tag, "_busy"}, 32'(busy_n), 32'd8);
      chk({tag, "_res"}, 32'({co8, sum8}), 32'(exp));
      tick();
      chk({tag, "_done_clr"}, 32'(done8), 32'd0);
   endtask

   task automatic rand_op();
      logic [15:0] ra, rb;
      logic        rc;
      logic        s1, s8, s16;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; c = rc; start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
      s1 = 1'b0; s8 = 1'b0; s16 = 1'b0;
      for (int j = 1; j <= 20 && !(s1 && s8 && s16); j++) begin
         tick();
         if (done1 && !s1) begin
            s1 = 1'b1;
            chk("r1_lat", 32'(j), 32'd1);
            chk("r1_res", 32'({co1, sum1}), 32'(ra[0]) + 32'(rb[0]) + 32'(rc));
         end
         if (done8 && !s8) begin
            s8 = 1'b1;
            chk("r8_lat", 32'(j), 32'd8);
            chk("r8_res", 32'({co8, sum8}), 32'(ra[7:0]) + 32'(rb[7:0]) + 32'(rc));
         end
         if (done16 && !s16) begin
            s16 = 1'b1;
            chk("r16_lat", 32'(j), 32'd16);
            chk("r16_res", 32'({co16, sum16}), 32'(ra) + 32'(rb) + 32'(rc));
         end
      end
      if (!s1)  chk("r1_timeout", 32'd0, 32'd1);
      if (!s8)  chk("r8_timeout", 32'd0, 32'd1);
      if (!s16) chk("r16_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ndone, t1, t2;
      logic [7:0] s;
      logic       co;

      rstn = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      tick();
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_res", 32'({co8, sum8}), 32'd0);
      chk("rst_busy_w1_w16", 32'({busy1, busy16}), 32'd0);

      directed8("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
      directed8("add_ff_01", 8'hFF, 8'h01, 1'b0);
      directed8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
      repeat (10) tick();

      // Restart during SHIFT is ignored; operand pins churn after the accept.
      a = 16'h10; b = 16'h20; c = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0; s = '0; co = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         a = (j == 3) ? 16'hFF : 16'($urandom);
         b = (j == 3) ? 16'hFF : 16'($urandom);
         start = (j == 3);
         tick();
         if (done8) begin
            ndone++;
            s  = sum8;
            co = co8;
         end
      end
      start = 1'b0;
      chk("ignore_ndone", 32'(ndone), 32'd1);
      chk("ignore_res", 32'({co, s}), 32'h030);
      repeat (10) tick();

      // Start held high: next request accepted on the done cycle.
      a = 16'h01; b = 16'h01; c = 1'b0; start = 1'b1;
      tick();
      t1 = -1; t2 = -1;
      for (int j = 1; j <= 30 && t2 < 0; j++) begin
         tick();
         if (done8) begin
            if (t1 < 0) begin
               t1 = j;
               chk("b2b_res1", 32'({co8, sum8}), 32'h002);
               a = 16'h02; b = 16'h03;
            end else begin
               t2 = j;
               chk("b2b_res2", 32'({co8, sum8}), 32'h005);
            end
         end
      end
      start = 1'b0;
      chk("b2b_first", 32'(t1), 32'd8);
      chk("b2b_gap", 32'(t2 - t1), 32'd9);
      repeat (20) tick();

      // Reset mid-operation aborts without a done pulse.
      a = 16'h80; b = 16'h80; c = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      repeat (4) begin
         tick();
         if (done8) ndone++;
      end
      rstn = 1'b0;
      tick();
      if (done8) ndone++;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_res", 32'({co8, sum8}), 32'd0);
      rstn = 1'b1;
      repeat (15) begin
         tick();
         if (done8) ndone++;
      end
      chk("abort_ndone", 32'(ndone), 32'd0);
      chk("abort_res_hold", 32'({co8, sum8}), 32'd0);

      for (int i = 0; i < 1000; i++) rand_op();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
